// File: rtl/wake_scheduler_pkg.sv
// Shared defines for the wake-up network: physical register number type,
// the Wake_Info broadcast bundle and the pending-FIFO depth default.
package wake_scheduler_pkg;

  localparam int unsigned PRF_W          = 6;  // physical register number width
  localparam int unsigned PEND_DEPTH_DEF = 4;  // pending FIFO entries, power of two, >= 4
  localparam int unsigned LATE_SRCS      = 3;  // LSU, MDU0, MDU1

  typedef logic [PRF_W-1:0] PRFNum;

  // Wake-up broadcast seen by every issue queue.
  typedef struct packed {
    logic  wen_0;
    logic  wen_1;
    logic  wen_2;
    logic  wen_3;
    PRFNum wb_num0_i;
    PRFNum wb_num1_i;
    PRFNum wb_num2_i;
    PRFNum wb_num3_i;
  } Wake_Info;

endpackage

// File: rtl/wake_scheduler_if.sv
// Wake scheduler bus: producer wake requests in, Wake_Info broadcast,
// late-producer stall and FIFO occupancy out.
//   master : producer / issue side (drives requests, reads broadcast)
//   slave  : wake_scheduler
interface wake_scheduler_if #(
  parameter int unsigned PEND_DEPTH = wake_scheduler_pkg::PEND_DEPTH_DEF
);
  localparam int unsigned CNT_W = $clog2(PEND_DEPTH) + 1;

  logic                      flush;
  logic                      alu_wake_0_en;
  logic                      alu_wake_1_en;
  wake_scheduler_pkg::PRFNum alu_wake_0;
  wake_scheduler_pkg::PRFNum alu_wake_1;
  logic                      lsu_wake_en;
  wake_scheduler_pkg::PRFNum lsu_wake;
  logic                      mdu_wake_0_en;
  logic                      mdu_wake_1_en;
  wake_scheduler_pkg::PRFNum mdu_wake_0;
  wake_scheduler_pkg::PRFNum mdu_wake_1;

  wake_scheduler_pkg::Wake_Info wake_Info;
  logic                         late_stall;
  logic [CNT_W-1:0]             pend_count;

  modport master (
    output flush, alu_wake_0_en, alu_wake_1_en, alu_wake_0, alu_wake_1,
           lsu_wake_en, lsu_wake, mdu_wake_0_en, mdu_wake_1_en, mdu_wake_0, mdu_wake_1,
    input  wake_Info, late_stall, pend_count
  );

  modport slave (
    input  flush, alu_wake_0_en, alu_wake_1_en, alu_wake_0, alu_wake_1,
           lsu_wake_en, lsu_wake, mdu_wake_0_en, mdu_wake_1_en, mdu_wake_0, mdu_wake_1,
    output wake_Info, late_stall, pend_count
  );

endinterface

// File: rtl/wake_scheduler_pend_fifo.sv
// wake_pend_fifo: in-order circular buffer of deferred late wakes.
// Accepts 0-3 pushes (compacted into slots 0..n-1) and 0-2 pops per cycle,
// exposes the two oldest entries and the occupancy count.
//   clk, rst     : clock, async active-high reset
//   i_flush      : clear pointers and count at the next edge
//   i_push_n     : number of valid entries in i_push_data
//   i_push_data  : entries to append, slot 0 oldest
//   i_pop_n      : number of head entries consumed this cycle
//   o_head0/1    : oldest and second-oldest entries
//   o_count      : occupancy
module wake_pend_fifo
  import wake_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = PEND_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic [1:0]                 i_push_n,
  input  PRFNum [LATE_SRCS-1:0]      i_push_data,
  input  logic [1:0]                 i_pop_n,
  output PRFNum                      o_head0,
  output PRFNum                      o_head1,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  PRFNum            r_mem [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= r_rptr + PTR_W'(i_pop_n);
      r_wptr  <= r_wptr + PTR_W'(i_push_n);
      r_count <= r_count - CNT_W'(i_pop_n) + CNT_W'(i_push_n);
    end
  end

  // Data storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LATE_SRCS); i++) begin
      if (!i_flush && (2'(i) < i_push_n)) begin
        r_mem[r_wptr + PTR_W'(i)] <= i_push_data[i];
      end
    end
  end

  assign o_head0 = r_mem[r_rptr];
  assign o_head1 = r_mem[r_rptr + PTR_W'(1)];
  assign o_count = r_count;

  // Producers honour late_stall, so a push into a full buffer is a bug upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(!i_flush && (i_push_n != 2'd0) && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/wake_scheduler.sv
// wake_scheduler: shares the four Wake_Info ports among all result producers.
// Ports 0/1 pass ALU0/ALU1 wakes straight through; ports 2/3 are granted to
// the pending FIFO head, head+1, LSU, MDU0, MDU1 in that priority. Losing
// late wakes are deferred in order and late_stall throttles their producers.
//   clk, rst : clock, async active-high reset
//   io_bus   : wake_scheduler_if slave (requests, flush, Wake_Info,
//              late_stall, pend_count)
module wake_scheduler
  import wake_scheduler_pkg::*;
#(
  parameter int unsigned PEND_DEPTH = PEND_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  wake_scheduler_if.slave  io_bus
);
  localparam int unsigned CNT_W  = $clog2(PEND_DEPTH) + 1;
  localparam int unsigned N_CAND = 5;

  PRFNum                  w_head0;
  PRFNum                  w_head1;
  logic [CNT_W-1:0]       w_count;
  logic [N_CAND-1:0]      w_cand_vld;
  PRFNum [N_CAND-1:0]     w_cand_num;
  PRFNum [LATE_SRCS-1:0]  w_push_data;
  logic [1:0]             w_push_n;
  logic [1:0]             w_pop_n;
  logic                   w_wen2;
  logic                   w_wen3;
  PRFNum                  w_port2;
  PRFNum                  w_port3;

  // Candidates in priority order, index 0 highest; flush kills all of them.
  assign w_cand_vld = {io_bus.mdu_wake_1_en,
                       io_bus.mdu_wake_0_en,
                       io_bus.lsu_wake_en,
                       (w_count >= CNT_W'(2)),
                       (w_count >= CNT_W'(1))} & {N_CAND{~io_bus.flush}};
  assign w_cand_num = {io_bus.mdu_wake_1, io_bus.mdu_wake_0, io_bus.lsu_wake,
                       w_head1, w_head0};

  // First two valid candidates win ports 2/3; remaining (new) ones are deferred.
  always_comb begin
    w_wen2      = 1'b0;
    w_wen3      = 1'b0;
    w_port2     = '0;
    w_port3     = '0;
    w_push_data = '0;
    w_push_n    = 2'd0;
    w_pop_n     = 2'd0;
    for (int i = 0; i < int'(N_CAND); i++) begin
      if (w_cand_vld[i]) begin
        if (!w_wen2) begin
          w_wen2  = 1'b1;
          w_port2 = w_cand_num[i];
          if (i < 2) w_pop_n = w_pop_n + 2'd1;
        end else if (!w_wen3) begin
          w_wen3  = 1'b1;
          w_port3 = w_cand_num[i];
          if (i < 2) w_pop_n = w_pop_n + 2'd1;
        end else begin
          case (w_push_n)
            2'd0:    w_push_data[0] = w_cand_num[i];
            2'd1:    w_push_data[1] = w_cand_num[i];
            default: w_push_data[2] = w_cand_num[i];
          endcase
          w_push_n = w_push_n + 2'd1;
        end
      end
    end
  end

  wake_pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (io_bus.flush),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .i_pop_n     (w_pop_n),
    .o_head0     (w_head0),
    .o_head1     (w_head1),
    .o_count     (w_count)
  );

  // Broadcast; every port, including the ALU pass-through, is held quiet in reset.
  always_comb begin
    io_bus.wake_Info = '0;
    if (!rst) begin
      io_bus.wake_Info.wen_0     = io_bus.alu_wake_0_en;
      io_bus.wake_Info.wb_num0_i = io_bus.alu_wake_0;
      io_bus.wake_Info.wen_1     = io_bus.alu_wake_1_en;
      io_bus.wake_Info.wb_num1_i = io_bus.alu_wake_1;
      io_bus.wake_Info.wen_2     = w_wen2;
      io_bus.wake_Info.wb_num2_i = w_port2;
      io_bus.wake_Info.wen_3     = w_wen3;
      io_bus.wake_Info.wb_num3_i = w_port3;
    end
  end

  // One free slot is kept so a full +1 growth cycle can never overflow.
  assign io_bus.late_stall = (w_count >= CNT_W'(PEND_DEPTH - 1));
  assign io_bus.pend_count = w_count;

endmodule

// File: tb/tb_wake_scheduler.sv
// Testbench for wake_scheduler: directed scenarios plus randomized traffic,
// expectations from a queue-based reference model, checked by a monitor.
module tb_wake_scheduler;
  import wake_scheduler_pkg::*;

  localparam int unsigned DEPTH = PEND_DEPTH_DEF;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wake_scheduler_if #(.PEND_DEPTH(DEPTH)) bus ();

  wake_scheduler #(.PEND_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    Wake_Info         wi;
    logic             stall;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic  r, f, a0e, a1e, le, m0e, m1e;
    PRFNum a0, a1, l, m0, m1;
  } stim_t;

  exp_t  exp_q[$];
  PRFNum pend_q[$];   // reference model: deferred late wakes, oldest first
  int    errors = 0;
  int    checks = 0;

  // Drive one cycle, predict the broadcast from the model, then advance the model.
  task automatic step(input stim_t s);
    exp_t  e;
    PRFNum cand[$];
    int    nf;
    @(posedge clk);
    #1;
    rst               = s.r;
    bus.flush         = s.f;
    bus.alu_wake_0_en = s.a0e;  bus.alu_wake_0 = s.a0;
    bus.alu_wake_1_en = s.a1e;  bus.alu_wake_1 = s.a1;
    bus.lsu_wake_en   = s.le;   bus.lsu_wake   = s.l;
    bus.mdu_wake_0_en = s.m0e;  bus.mdu_wake_0 = s.m0;
    bus.mdu_wake_1_en = s.m1e;  bus.mdu_wake_1 = s.m1;

    e.wi    = '0;
    e.stall = 1'b0;
    e.cnt   = '0;
    nf      = 0;
    if (s.r) begin
      pend_q.delete();
    end else begin
      e.wi.wen_0     = s.a0e;
      e.wi.wb_num0_i = s.a0;
      e.wi.wen_1     = s.a1e;
      e.wi.wb_num1_i = s.a1;
      e.cnt   = CNT_W'(pend_q.size());
      e.stall = (pend_q.size() >= int'(DEPTH) - 1);
      if (!s.f) begin
        for (int i = 0; i < 2 && i < pend_q.size(); i++) cand.push_back(pend_q[i]);
        nf = cand.size();
        if (s.le)  cand.push_back(s.l);
        if (s.m0e) cand.push_back(s.m0);
        if (s.m1e) cand.push_back(s.m1);
        if (cand.size() > 0) begin e.wi.wen_2 = 1'b1; e.wi.wb_num2_i = cand[0]; end
        if (cand.size() > 1) begin e.wi.wen_3 = 1'b1; e.wi.wb_num3_i = cand[1]; end
      end
    end
    exp_q.push_back(e);

    if (s.r || s.f) begin
      pend_q.delete();
    end else begin
      repeat (nf) void'(pend_q.pop_front());
      for (int i = 2; i < cand.size(); i++) pend_q.push_back(cand[i]);
    end
  endtask

  // Monitor: the DUT presents a broadcast every cycle; compare mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.wake_Info !== e.wi) begin
        errors++;
        $display("FAIL wake_info t=%0t: got %h expected %h", $time, bus.wake_Info, e.wi);
      end
      checks++;
      if (bus.late_stall !== e.stall) begin
        errors++;
        $display("FAIL late_stall t=%0t: got %b expected %b", $time, bus.late_stall, e.stall);
      end
      checks++;
      if (bus.pend_count !== e.cnt) begin
        errors++;
        $display("FAIL pend_count t=%0t: got %0d expected %0d", $time, bus.pend_count, e.cnt);
      end
    end
  end

  function automatic stim_t three(input PRFNum base);
    stim_t s;
    s = '0;
    s.le  = 1'b1; s.l  = base;
    s.m0e = 1'b1; s.m0 = base + PRFNum'(1);
    s.m1e = 1'b1; s.m1 = base + PRFNum'(2);
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.alu_wake_0_en = 1'b0; bus.alu_wake_0 = '0;
    bus.alu_wake_1_en = 1'b0; bus.alu_wake_1 = '0;
    bus.lsu_wake_en   = 1'b0; bus.lsu_wake   = '0;
    bus.mdu_wake_0_en = 1'b0; bus.mdu_wake_0 = '0;
    bus.mdu_wake_1_en = 1'b0; bus.mdu_wake_1 = '0;

    // Reset state
    s = '0; s.r = 1'b1;
    step(s); step(s);

    // ALU pass-through
    s = '0; s.a0e = 1'b1; s.a0 = 6'd5; s.a1e = 1'b1; s.a1 = 6'd9;
    step(s);

    // Two late wakes, both granted in their arrival cycle
    s = '0; s.le = 1'b1; s.l = 6'd12; s.m0e = 1'b1; s.m0 = 6'd20;
    step(s);

    // Three late wakes: MDU1 deferred one cycle
    s = '0; s.le = 1'b1; s.l = 6'd12; s.m0e = 1'b1; s.m0 = 6'd20;
    s.m1e = 1'b1; s.m1 = 6'd21;
    step(s);
    s = '0; step(s);
    step(s);

    // Three arrivals for three cycles: count 1,2,3, stall, ordered drain
    step(three(6'd40)); step(three(6'd43)); step(three(6'd46));
    s = '0; step(s); step(s); step(s); step(s);

    // Count 2, then flush with a concurrent LSU=30
    step(three(6'd50)); step(three(6'd53));
    s = '0; s.f = 1'b1; s.le = 1'b1; s.l = 6'd30;
    s.a0e = 1'b1; s.a0 = 6'd1;
    step(s);
    s = '0; step(s); step(s);

    // Reset while count=3, ALU enables held high
    step(three(6'd56)); step(three(6'd59)); step(three(6'd62));
    s = '0; s.r = 1'b1; s.a0e = 1'b1; s.a0 = 6'd7; s.a1e = 1'b1; s.a1 = 6'd8;
    step(s);
    s = '0; s.r = 1'b1; step(s);
    s = '0; step(s); step(s); step(s);

    // Randomized traffic; late producers honour the model's stall
    for (int n = 0; n < 400; n++) begin
      s = '0;
      s.a0e = 1'($urandom_range(0, 1)); s.a0 = PRFNum'($urandom);
      s.a1e = 1'($urandom_range(0, 1)); s.a1 = PRFNum'($urandom);
      s.l  = PRFNum'($urandom);
      s.m0 = PRFNum'($urandom);
      s.m1 = PRFNum'($urandom);
      if (pend_q.size() < int'(DEPTH) - 1) begin
        s.le  = ($urandom_range(0, 9) < 6);
        s.m0e = ($urandom_range(0, 9) < 5);
        s.m1e = ($urandom_range(0, 9) < 5);
      end
      s.f = ($urandom_range(0, 19) == 0);
      s.r = ($urandom_range(0, 79) == 0);
      step(s);
    end
    s = '0; step(s); step(s); step(s);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wake_scheduler.md
# wake_scheduler

Shares the four `Wake_Info` wake-up ports that feed every issue queue among all result producers. ALU0/ALU1 issue-time wakes own ports 0/1 with zero latency. LSU load-return and the two MDU result wakes (HI/LO renamed destinations) compete for ports 2/3. Losers are held in a small in-order pending FIFO and replayed ahead of newer requests, with a stall back to the late producers so no wake is ever lost.

## Interface
- `PEND_DEPTH`, 4, pending FIFO entries; must be ≥ 4.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline flush; drops pending and current late wakes.
- `alu_wake_0_en` / `alu_wake_1_en` in 1 each: ALU issue-time wake valid (from `wake_reg_0_en` / `wake_reg_1_en` of the ALU issue unit).
- `alu_wake_0` / `alu_wake_1` in PRFNum each: ALU destination physical register.
- `lsu_wake_en` in 1, `lsu_wake` in PRFNum: load data return.
- `mdu_wake_0_en` / `mdu_wake_1_en` in 1 each, `mdu_wake_0` / `mdu_wake_1` in PRFNum each: MDU HI/LO or GPR results.
- `wake_Info` out Wake_Info: `wen_0..3`, `wb_num0_i..wb_num3_i`, broadcast to all issue queues.
- `late_stall` out 1: LSU/MDU must not assert any wake enable next cycle while high.
- `pend_count` out $clog2(PEND_DEPTH)+1: FIFO occupancy, for debug and verification.

## Operation
- Ports 0/1:
  - `wen_0 = alu_wake_0_en`, `wb_num0_i = alu_wake_0`; same for ALU1 on port 1.
  - Pure pass-through. Never arbitrated, never buffered.
- Ports 2/3 candidate priority, highest first:
  1. FIFO head
  2. FIFO head+1
  3. LSU
  4. MDU0
  5. MDU1
- Grant rule:
  - The first valid candidate takes port 2; the second valid candidate takes port 3.
  - Unused port: `wen`=0, `wb_num`=0.
- Dequeue: the number of FIFO entries granted this cycle (0–2) is popped at the clock edge.
- Enqueue: ungranted valid new requests are pushed at the clock edge in order LSU, MDU0, MDU1, behind existing entries.
- Occupancy: the FIFO is circular, with 2-bit-wrapped read/write pointers and a separate counter. Next count = count − popped + pushed. Maximum net growth is +1 per cycle.
- `late_stall` = (count ≥ PEND_DEPTH−1), decoded from the registered count.
  - Producers honour it, so overflow is impossible.
  - A push while count = PEND_DEPTH is an assertion failure.
- Flush:
  - Same cycle: `wen_2`/`wen_3` are forced to 0 and nothing is pushed.
  - Next edge: the FIFO pointers and count are cleared.
  - `wen_0`/`wen_1` still pass through; the ALU issue unit gates its own enables during flush.
- No duplicate filtering; two identical `wb_num` values on different ports are legal.
- Register number 0 is treated like any other register.

## Timing
- Reset values while `rst`=1: count=0, pointers=0, `late_stall`=0, all `wen_*`=0, all `wb_num*`=0.
  - Ports 0/1 are also forced to 0 during reset.
- Latency:
  - ALU wakes: 0 cycles.
  - LSU/MDU wake: 0 cycles if granted in its arrival cycle.
  - Otherwise it appears on port 2/3 k cycles later, where k ≥ 1 is set by FIFO position.
- Order: late wakes leave in arrival order. Within one arrival cycle the order is LSU, MDU0, MDU1.
- Handshake: `late_stall` is registered-state based. Producers sample it and suppress their enables in that same cycle.
- Simultaneous events:
  - FIFO with 2 entries plus 3 new requests: both FIFO entries are granted and all 3 new requests are pushed (count 2→3).
  - Flush together with arrivals: the arrivals are discarded.
- Reset mid-operation: pending wakes are discarded immediately (asynchronous).

## Structure
- The `Wake_Info` typedef, PRFNum and the `PEND_DEPTH` default belong in the shared defines package, next to the existing queue meta typedefs.
- One sub-module, `wake_pend_fifo`: circular buffer with 0–3 push and 0–2 pop per cycle, exposing head/head+1 entries and count.
- Grant and pass-through logic stays in `wake_scheduler`.

## Test plan
- Reset, then ALU0=5 and ALU1=9 with no late wakes → same cycle `wen_0`=1/`wb_num0_i`=5 and `wen_1`=1/`wb_num1_i`=9; `wen_2`=`wen_3`=0; count=0.
- LSU=12 and MDU0=20 with FIFO empty → port 2=12, port 3=20 same cycle; count stays 0.
- LSU=12, MDU0=20, MDU1=21 → ports 2/3 = 12/20; count=1; next cycle with no arrivals port 2=21, count=0.
- Three arrivals on each of 3 consecutive cycles → count goes 1, 2, 3; `late_stall`=1 once count=3; drained FIFO output order matches arrival order exactly.
- Count=2 plus flush together with LSU=30 → `wen_2`=`wen_3`=0 that cycle; count=0 next cycle; 30 never appears.
- Assert `rst` while count=3 → all `wen` deassert asynchronously; count=0; `late_stall`=0; no pending wake is emitted after release.
